// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and perf-monitor state type.
// Imported by the retirement-side performance counter unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } perf_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones.
// Used for every statistic in the perf counter unit.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Retirement perf monitor: counts and classifies retired instructions,
// detects end of program (syscall or watchdog) and freezes the counts.
module perf_counter_unit
  import mips_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  output logic [WIDTH-1:0] instructionCount,
  output logic [WIDTH-1:0] cycleCount,
  output logic [WIDTH-1:0] loadCount,
  output logic [WIDTH-1:0] storeCount,
  output logic [WIDTH-1:0] branchCount,
  output logic [WIDTH-1:0] takenCount,
  output logic [WIDTH-1:0] jumpCount,
  output logic             runStats,
  output logic             timeout
);

  perf_state_t state_q, state_d;
  logic        timeout_q, timeout_d;

  logic [5:0] op;
  logic [5:0] fn;
  logic       is_ld, is_st, is_br, is_jp, is_sys;
  logic       retire, cyc_en, wd_hit;
  logic [63:0] cyc_ext;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_br  = 1'b0;
    is_jp  = 1'b0;
    is_sys = 1'b0;
    unique case (1'b1)
      (op == OP_LW):                        is_ld  = 1'b1;
      (op == OP_SW):                        is_st  = 1'b1;
      (op == OP_BEQ), (op == OP_BNE):       is_br  = 1'b1;
      (op == OP_J), (op == OP_JAL):         is_jp  = 1'b1;
      (op == OP_RTYPE && fn == FN_JR):      is_jp  = 1'b1;
      (op == OP_RTYPE && fn == FN_SYSCALL): is_sys = 1'b1;
      default: ;
    endcase
  end

  // IDLE counts the first retirement on the same edge it leaves IDLE
  assign retire  = instr_valid && (state_q != HALTED);
  assign cyc_en  = (state_q == RUN) || retire;
  assign cyc_ext = 64'(cycleCount);
  assign wd_hit  = cyc_en &&
                   (cyc_ext + 64'd1 == {32'd0, MAX_CYCLES});

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (retire && is_sys) begin
          state_d = HALTED;
        end else if (wd_hit) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end else if (retire) begin
          state_d = RUN;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.WIDTH(WIDTH)) u_ins (
    .clk(clk), .reset(reset), .en(retire), .q(instructionCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_cyc (
    .clk(clk), .reset(reset), .en(cyc_en), .q(cycleCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_ld (
    .clk(clk), .reset(reset), .en(retire && is_ld), .q(loadCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_st (
    .clk(clk), .reset(reset), .en(retire && is_st), .q(storeCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_br (
    .clk(clk), .reset(reset), .en(retire && is_br), .q(branchCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_tk (
    .clk(clk), .reset(reset),
    .en(retire && is_br && branch_taken), .q(takenCount)
  );
  sat_counter #(.WIDTH(WIDTH)) u_jp (
    .clk(clk), .reset(reset), .en(retire && is_jp), .q(jumpCount)
  );

  assign runStats = (state_q == HALTED);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: three configurations share one stimulus
// stream and are checked against a trace-scanning reference model.
module tb_perf_counter_unit;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_SYS  = 32'h0000000C;

  typedef struct {
    bit          v;
    logic [31:0] ins;
    bit          tk;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        branch_taken = 1'b0;

  logic [31:0] a_o [7];
  logic [31:0] b_o [7];
  logic [3:0]  c_o [7];
  logic        a_rs, a_to, b_rs, b_to, c_rs, c_to;

  logic [31:0] ob    [3][9];
  logic [31:0] exp_q [3][9];
  string       nm [9] = '{"instr", "cycle", "load", "store",
                          "branch", "taken", "jump", "runStats",
                          "timeout"};

  ent_t tr[$];
  int   total = 0;
  int   pass  = 0;

  always #5 clk = ~clk;

  perf_counter_unit u_a (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr(instr), .branch_taken(branch_taken),
    .instructionCount(a_o[0]), .cycleCount(a_o[1]),
    .loadCount(a_o[2]), .storeCount(a_o[3]),
    .branchCount(a_o[4]), .takenCount(a_o[5]),
    .jumpCount(a_o[6]), .runStats(a_rs), .timeout(a_to)
  );

  perf_counter_unit #(.MAX_CYCLES(32'd10)) u_b (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr(instr), .branch_taken(branch_taken),
    .instructionCount(b_o[0]), .cycleCount(b_o[1]),
    .loadCount(b_o[2]), .storeCount(b_o[3]),
    .branchCount(b_o[4]), .takenCount(b_o[5]),
    .jumpCount(b_o[6]), .runStats(b_rs), .timeout(b_to)
  );

  perf_counter_unit #(.WIDTH(4)) u_c (
    .clk(clk), .reset(reset), .instr_valid(instr_valid),
    .instr(instr), .branch_taken(branch_taken),
    .instructionCount(c_o[0]), .cycleCount(c_o[1]),
    .loadCount(c_o[2]), .storeCount(c_o[3]),
    .branchCount(c_o[4]), .takenCount(c_o[5]),
    .jumpCount(c_o[6]), .runStats(c_rs), .timeout(c_to)
  );

  always_comb begin
    for (int j = 0; j < 7; j++) begin
      ob[0][j] = a_o[j];
      ob[1][j] = b_o[j];
      ob[2][j] = {28'd0, c_o[j]};
    end
    ob[0][7] = {31'd0, a_rs};
    ob[0][8] = {31'd0, a_to};
    ob[1][7] = {31'd0, b_rs};
    ob[1][8] = {31'd0, b_to};
    ob[2][7] = {31'd0, c_rs};
    ob[2][8] = {31'd0, c_to};
  end

  // Reference: scan the trace since reset; program starts at the first
  // valid, ends at a syscall or when the cycle total hits the limit.
  task automatic compute_expected();
    longint c [9];
    int     w;
    longint mx;
    bit     started;
    ent_t   e;
    logic [5:0] op, fn;
    for (int k = 0; k < 3; k++) begin
      w  = (k == 2) ? 4 : 32;
      mx = (k == 1) ? 10 : 100000;
      for (int j = 0; j < 9; j++) c[j] = 0;
      started = 0;
      foreach (tr[i]) begin
        e = tr[i];
        if (!started && !e.v) continue;
        started = 1;
        c[1]++;
        if (e.v) begin
          op = e.ins[31:26];
          fn = e.ins[5:0];
          c[0]++;
          if (op == 6'h23) c[2]++;
          if (op == 6'h2B) c[3]++;
          if (op == 6'h04 || op == 6'h05) begin
            c[4]++;
            if (e.tk) c[5]++;
          end
          if (op == 6'h02 || op == 6'h03 ||
              (op == 6'h00 && fn == 6'h08)) c[6]++;
          if (op == 6'h00 && fn == 6'h0C) begin
            c[7] = 1;
            break;
          end
        end
        if (c[1] == mx) begin
          c[7] = 1;
          c[8] = 1;
          break;
        end
      end
      for (int j = 0; j < 7; j++)
        if (c[j] > (64'd1 << w) - 1) c[j] = (64'd1 << w) - 1;
      for (int j = 0; j < 9; j++) exp_q[k][j] = c[j][31:0];
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit tk);
    ent_t e;
    instr_valid  = v;
    instr        = ins;
    branch_taken = tk;
    e.v = v; e.ins = ins; e.tk = tk;
    tr.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Reset asserted alongside a valid syscall: reset must win
  task automatic do_reset();
    reset        = 1'b1;
    instr_valid  = 1'b1;
    instr        = I_SYS;
    branch_taken = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_valid = 1'b0;
    tr.delete();
  endtask

  task automatic test_reset();
    do_reset();
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL reset dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
    total++;
    if (a_o[1] !== 32'd0 || a_rs !== 1'b0)
      $display("FAIL reset_const cycle %0d rs %0b want 0/0", a_o[1], a_rs);
    else pass++;
  endtask

  task automatic test_add_syscall();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, I_ADD, 0);
    step(1, I_SYS, 0);
    total++;
    if (a_o[0] !== 32'd6 || a_o[1] !== 32'd6 || a_rs !== 1'b1 ||
        a_to !== 1'b0)
      $display("FAIL add_sys ins %0d cyc %0d rs %0b to %0b want 6 6 1 0",
               a_o[0], a_o[1], a_rs, a_to);
    else pass++;
    step(1, I_LW, 0);
    step(1, I_SYS, 0);
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL add_sys dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
  endtask

  task automatic test_mix();
    logic [31:0] seq [7] = '{I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JR, I_SYS};
    bit          tks [7] = '{1, 0, 1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) step(1, seq[i], tks[i]);
    total++;
    if (a_o[2] !== 1 || a_o[3] !== 1 || a_o[4] !== 2 || a_o[5] !== 1 ||
        a_o[6] !== 2 || a_o[0] !== 7)
      $display("FAIL mix ld %0d st %0d br %0d tk %0d jp %0d ins %0d want 1 1 2 1 2 7",
               a_o[2], a_o[3], a_o[4], a_o[5], a_o[6], a_o[0]);
    else pass++;
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL mix dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, I_ADD, 0);
    step(0, I_ADD, 0);
    step(1, I_ADD, 0);
    step(1, I_JAL, 0);
    for (int i = 0; i < 3; i++) step(0, I_LW, 1);
    step(1, I_ADD, 0);
    step(1, I_BNE, 1);
    step(1, I_SYS, 0);
    total++;
    if (a_o[0] !== 32'd5 || a_o[1] !== 32'd8)
      $display("FAIL stall ins %0d cyc %0d want 5 8", a_o[0], a_o[1]);
    else pass++;
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL stall dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
  endtask

  task automatic test_watchdog_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) step(1, (i % 3 == 0) ? I_LW : I_ADD, 0);
    total++;
    if (b_o[1] !== 32'd10 || b_to !== 1'b1 || b_rs !== 1'b1 ||
        b_o[0] !== 32'd10)
      $display("FAIL watchdog cyc %0d to %0b rs %0b ins %0d want 10 1 1 10",
               b_o[1], b_to, b_rs, b_o[0]);
    else pass++;
    total++;
    if (c_o[0] !== 4'd15 || c_o[1] !== 4'd15 || c_rs !== 1'b0)
      $display("FAIL saturate ins %0d cyc %0d rs %0b want 15 15 0",
               c_o[0], c_o[1], c_rs);
    else pass++;
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL wd_sat dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
  endtask

  task automatic test_first_syscall();
    do_reset();
    step(0, I_ADD, 0);
    step(1, I_SYS, 0);
    step(1, I_LW, 0);
    total++;
    if (a_o[0] !== 1 || a_o[1] !== 1 || a_rs !== 1 || a_to !== 0)
      $display("FAIL first_sys ins %0d cyc %0d rs %0b to %0b want 1 1 1 0",
               a_o[0], a_o[1], a_rs, a_to);
    else pass++;
    compute_expected();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        total++;
        if (ob[k][j] !== exp_q[k][j])
          $display("FAIL first_sys dut%0d.%s got %0d want %0d",
                   k, nm[j], ob[k][j], exp_q[k][j]);
        else pass++;
      end
  endtask

  task automatic test_random();
    logic [31:0] pool [16] = '{I_ADD, I_LW, I_SW, I_BEQ, I_BNE, I_J,
                               I_JAL, I_JR, I_ADD, I_LW, I_BEQ, I_BNE,
                               I_ADD, I_SW, I_JR, I_SYS};
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int n = 0; n < 30; n++) begin
        step(($urandom % 4) != 0, pool[$urandom % 16], $urandom % 2);
        compute_expected();
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < 9; j++) begin
            total++;
            if (ob[k][j] !== exp_q[k][j])
              $display("FAIL random r%0d n%0d dut%0d.%s got %0d want %0d",
                       r, n, k, nm[j], ob[k][j], exp_q[k][j]);
            else pass++;
          end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_syscall();
    test_mix();
    test_reset();
    test_stall();
    test_watchdog_saturate();
    test_reset();
    test_first_syscall();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
# perf_counter_unit

Retirement-side performance monitor for the single-cycle MIPS core. It sits between the datapath and the statistics printer. It counts retired instructions and cycles, classifies them (load/store/branch/jump), and detects end of program (a `syscall` or a watchdog timeout). When the program ends it freezes all counters and raises `runStats`, the one-shot trigger the statistics module consumes together with `instructionCount`.

## Interface
Parameters:
- `WIDTH`, 32: width of every counter output.
- `MAX_CYCLES`, 32'd100000: watchdog limit on `cycleCount` in RUN.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on posedge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `instr_valid`  in  1  an instruction retires this cycle.
- `instr`  in  32  retiring instruction word, qualified by `instr_valid`.
- `branch_taken`  in  1  retiring branch was taken, qualified by `instr_valid`.
- `instructionCount`  out  WIDTH  retired instructions.
- `cycleCount`  out  WIDTH  cycles spent in RUN, including the entry and halt cycles.
- `loadCount`, `storeCount`, `branchCount`, `takenCount`, `jumpCount`  out  WIDTH each  class counters.
- `runStats`  out  1  level; rises once at end of program and stays high until reset.
- `timeout`  out  1  end of program was caused by the watchdog.

## Operation
- States: IDLE (after reset), RUN, HALTED.
- IDLE: counters hold 0. The first `instr_valid` moves to RUN, and that instruction and cycle are counted on the same edge.
- RUN:
  - `cycleCount` +1 every edge.
  - On `instr_valid`: `instructionCount` +1 and class counters per decode.
- Decode uses `instr[31:26]` as op and `instr[5:0]` as funct:
  - op 0x23 (lw) → load.
  - op 0x2B (sw) → store.
  - op 0x04/0x05 (beq/bne) → branch, and taken as well if `branch_taken`.
  - op 0x02/0x03 (j/jal), or op 0 with funct 0x08 (jr) → jump.
  - All others update only `instructionCount`.
- `branch_taken` is ignored for non-branches.
- Halt: a valid `syscall` (op 0, funct 0x0C) in RUN is counted as an instruction, then the state goes to HALTED.
- Watchdog: when `cycleCount` would reach `MAX_CYCLES` on this edge, go to HALTED with `timeout`=1. The instruction retiring on that edge is still counted.
- If syscall and watchdog occur on the same edge, syscall wins and `timeout`=0.
- HALTED: all counters frozen, `instr_valid` ignored, `runStats`=1. Only `reset` exits.
- A syscall as the very first instruction (in IDLE) moves directly to HALTED. All counters, including `cycleCount`, read 1 and `runStats`=1.
- Counters saturate at 2^WIDTH−1 and never wrap.

## Timing
- Reset values: all counters 0, `runStats`=0, `timeout`=0, state IDLE. Reset has priority over every other input on the same edge, including mid-RUN and in HALTED.
- All outputs are registered. Counts reflect an instruction one edge after it retires.
- `runStats` rises on the same edge that registers the final counts. The consumer samples stable, final values on its change.
- Single-cycle core (`instr_valid` held high): `instructionCount` == `cycleCount` at halt.
- `instr_valid`=0 cycles in RUN still advance `cycleCount`.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`;
  - funct constants `FN_JR`, `FN_SYSCALL`;
  - state enum `perf_state_t` {IDLE, RUN, HALTED}.
- One sub-module `sat_counter` (params `WIDTH`; ports `clk`, `reset`, `en`, `q`), instantiated seven times.
- Decode and FSM live in the top.

## Test plan
- Reset, then 5 cycles of valid `add` followed by valid `syscall` (0x0000000C) → one edge later: `instructionCount`=6, `cycleCount`=6, `runStats`=1, `timeout`=0.
- Mix lw, sw, beq taken, bne not taken, j, jr, then syscall, `instr_valid` always high → load=1, store=1, branch=2, taken=1, jump=2, instr=7.
- `instr_valid` low for 3 cycles mid-program (4 instructions + syscall) → `instructionCount`=5, `cycleCount`=8. Stalls before the first instruction are not counted.
- `MAX_CYCLES`=10, no syscall → `cycleCount`=10, `timeout`=1, `runStats`=1. Further `instr_valid` pulses do not change any count.
- Assert `reset` for one cycle mid-RUN and again in HALTED → all outputs 0 next edge, state IDLE; a new program counts from 0.
- `WIDTH`=4, 20 instructions → `instructionCount` holds at 15 with no wrap.
